// File: rtl/uart_wb_initiator_pkg.sv
// Shared constants and types for the serial-to-Wishbone initiator.
// Optional abort-on-no-ack behaviour is enabled by defining UART_WB_TIMEOUT_EN.
package uart_wb_initiator_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WDATA = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_REPLY = 3'd4;

  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  localparam int FRAME_DATA_BYTES = 4;

  typedef struct packed {
    logic [2:0] state;
    logic [1:0] byte_cnt;
  } dbg_t;

  // A single status byte travels in the top lane of the reply word.
  function automatic logic [31:0] single_byte_word(input logic [7:0] b);
    return {b, 24'h000000};
  endfunction

endpackage

// File: rtl/uart_wb_reply.sv
// Byte serializer: loads a 32-bit word plus a byte count and emits the
// bytes MSB first over a valid/ready handshake.
module uart_wb_reply (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic [2:0]  len_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        last_o
);

  logic [31:0] shift_q, shift_d;
  logic [2:0]  cnt_q, cnt_d;

  // Handshake: data_o/valid_o hold steady until a cycle where valid_o and
  // ready_i are both high; that cycle transfers exactly one byte.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shift_d = word_i;
      cnt_d   = len_i;
    end else if (valid_o && ready_i) begin
      shift_d = {shift_q[23:0], 8'h00};
      cnt_d   = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= 32'h0;
      cnt_q   <= 3'd0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_o  = shift_q[31:24];
  assign valid_o = (cnt_q != 3'd0);
  assign last_o  = (cnt_q == 3'd1);

endmodule

// File: rtl/uart_wb_initiator.sv
// Serial command frames in, one single-beat Wishbone B4 pipelined access out,
// result bytes back. Define UART_WB_TIMEOUT_EN to abort after TIMEOUT cycles.
module uart_wb_initiator
  import uart_wb_initiator_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_stall_i,
  input  logic                  wb_ack_i,
  output dbg_t                  dbg_o
);

  logic [2:0]            state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [31:0]           dat_q, dat_d;

  logic        rep_load;
  logic [31:0] rep_word;
  logic [2:0]  rep_len;
  logic        rep_last;
  logic        tx_fire;
  logic        in_bus;
  logic        tmo_hit;
  logic        unused_rsvd;

  assign in_bus      = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign tx_fire     = tx_valid_o && tx_ready_i;
  // Reserved command bits carry no meaning and are deliberately dropped.
  assign unused_rsvd = ^rx_data_i;

`ifdef UART_WB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TW-1:0] tmo_q, tmo_d;

  // Zero outside the bus phase, so every entry into REQ starts from zero.
  always_comb begin
    tmo_d = '0;
    if (in_bus) tmo_d = tmo_q + TW'(1);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end

  assign tmo_hit = in_bus && (tmo_q == TW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    rep_load = 1'b0;
    rep_word = 32'h0;
    rep_len  = 3'd0;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid_i) begin
          we_d    = rx_data_i[7];
          adr_d   = rx_data_i[ADDR_WIDTH-1:0];
          cnt_d   = 2'd0;
          state_d = rx_data_i[7] ? ST_WDATA : ST_REQ;
        end
      end
      ST_WDATA: begin
        if (rx_valid_i) begin
          dat_d = {dat_q[23:0], rx_data_i};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'(FRAME_DATA_BYTES - 1)) state_d = ST_REQ;
        end
      end
      ST_REQ, ST_WAIT: begin
        // An ack in the accepting REQ cycle completes the access directly.
        if (wb_ack_i && ((state_q == ST_WAIT) || !wb_stall_i)) begin
          rep_load = 1'b1;
          rep_word = we_q ? single_byte_word(ACK_BYTE) : wb_dat_i;
          rep_len  = we_q ? 3'd1 : 3'(FRAME_DATA_BYTES);
          state_d  = ST_REPLY;
        end else if (tmo_hit) begin
          rep_load = 1'b1;
          rep_word = single_byte_word(NAK_BYTE);
          rep_len  = 3'd1;
          state_d  = ST_REPLY;
        end else if ((state_q == ST_REQ) && !wb_stall_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_REPLY: begin
        if (tx_fire && rep_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  uart_wb_reply u_reply (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .load_i  (rep_load),
    .word_i  (rep_word),
    .len_i   (rep_len),
    .data_o  (tx_data_o),
    .valid_o (tx_valid_o),
    .ready_i (tx_ready_i),
    .last_o  (rep_last)
  );

  // Bus strobes decode straight from state so reset drops them at once.
  assign wb_cyc_o = in_bus;
  assign wb_stb_o = (state_q == ST_REQ);
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;

  assign dbg_o.state    = state_q;
  assign dbg_o.byte_cnt = cnt_q;

endmodule

// File: tb/tb_uart_wb_initiator.sv
// Directed plus randomized bench for uart_wb_initiator with a frame-level
// reference model and an expected-reply-byte queue.
module tb_uart_wb_initiator;
  import uart_wb_initiator_pkg::*;

  localparam int AW  = 4;
  localparam int TMO = 8;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic [7:0]    rx_data  = 8'h00;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          cyc, stb, we;
  logic [AW-1:0] adr;
  logic [31:0]   dat_o;
  logic [31:0]   dat_i    = 32'h0;
  logic          stall    = 1'b0;
  logic          ack      = 1'b0;
  dbg_t          dbg;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  uart_wb_initiator #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .wb_cyc_o   (cyc),
    .wb_stb_o   (stb),
    .wb_we_o    (we),
    .wb_adr_o   (adr),
    .wb_dat_o   (dat_o),
    .wb_dat_i   (dat_i),
    .wb_stall_i (stall),
    .wb_ack_i   (ack),
    .dbg_o      (dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] data);
    send_byte(cmd);
    if (cmd[7]) begin
      check("stb_before_data", stb, 1'b0);
      for (int i = 3; i >= 0; i--) begin
        send_byte(data[8*i +: 8]);
        if (i != 0) check("stb_mid_data", stb, 1'b0);
      end
    end
  endtask

  task automatic noise(input bit en);
    if (en) begin
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom);
    end
  endtask

  task automatic run_bus(input logic exp_we, input logic [AW-1:0] exp_adr, input logic [31:0] exp_dat,
                         input int stalls, input int ack_dly, input logic [31:0] rdata, input bit nz);
    check("stb_rise", stb, 1'b1);
    check("cyc_rise", cyc, 1'b1);
    check("we", we, exp_we);
    check("adr", adr, exp_adr);
    if (exp_we) check("wdat", dat_o, exp_dat);
    for (int i = 0; i < stalls; i++) begin
      stall = 1'b1;
      dat_i = $urandom;
      noise(nz);
      step();
      check("stb_held", stb, 1'b1);
      check("cyc_held", cyc, 1'b1);
    end
    stall = 1'b0;
    if (ack_dly == 0) begin
      ack   = 1'b1;
      dat_i = rdata;
      step();
    end else begin
      noise(nz);
      step();
      check("stb_drop", stb, 1'b0);
      check("cyc_wait", cyc, 1'b1);
      for (int i = 1; i < ack_dly; i++) begin
        noise(nz);
        step();
        check("cyc_wait", cyc, 1'b1);
        check("tx_quiet", tx_valid, 1'b0);
      end
      ack   = 1'b1;
      dat_i = rdata;
      step();
    end
    ack      = 1'b0;
    rx_valid = 1'b0;
    dat_i    = $urandom;
    check("cyc_drop", cyc, 1'b0);
    check("stb_after_ack", stb, 1'b0);
    check("tx_valid_rise", tx_valid, 1'b1);
  endtask

  // mode 0: ready held high, 1: ready toggles, 2: random ready
  task automatic collect_reply(input int n, input int mode);
    int   got  = 0;
    int   cnt  = 0;
    logic fire;
    while (got < n && cnt < 64) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = cnt[0];
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      check("tx_valid", tx_valid, 1'b1);
      check("tx_data", tx_data, exp_q[0]);
      fire = tx_valid && tx_ready;
      step();
      cnt++;
      if (fire) begin
        void'(exp_q.pop_front());
        got++;
      end
    end
    tx_ready = 1'b0;
    check("reply_count", got, n);
    if (mode == 0) check("reply_cycles", cnt, n);
    check("tx_idle", tx_valid, 1'b0);
    check("cyc_idle", cyc, 1'b0);
    check("state_idle", dbg.state, ST_IDLE);
  endtask

  // Reference model: a frame is {we, reserved, adr} then 4 data bytes MSB
  // first for writes; the reply is ACK for writes, the read word otherwise.
  task automatic do_txn(input logic [7:0] cmd, input logic [31:0] data, input logic [31:0] rdata,
                        input int stalls, input int ack_dly, input int mode, input bit nz);
    logic          m_we;
    logic [AW-1:0] m_adr;
    m_we  = cmd[7];
    m_adr = cmd[AW-1:0];
    send_frame(cmd, data);
    run_bus(m_we, m_adr, data, stalls, ack_dly, rdata, nz);
    if (m_we) exp_q.push_back(ACK_BYTE);
    else for (int i = 3; i >= 0; i--) exp_q.push_back(rdata[8*i +: 8]);
    collect_reply(m_we ? 1 : 4, mode);
    step();
    check("no_second_cycle", cyc, 1'b0);
  endtask

  initial begin
    repeat (3) step();
    check("rst_cyc", cyc, 1'b0);
    check("rst_stb", stb, 1'b0);
    check("rst_we", we, 1'b0);
    check("rst_adr", adr, 0);
    check("rst_dat", dat_o, 32'h0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_state", dbg.state, ST_IDLE);
    rst = 1'b0;
    step();

    do_txn(8'h83, 32'hDEADBEEF, $urandom, 0, 1, 0, 1'b0);
    do_txn(8'h05, 32'h0, 32'h12345678, 3, 0, 0, 1'b0);
    do_txn(8'h05, 32'h0, 32'h12345678, 0, 1, 1, 1'b0);
    do_txn(8'h07, 32'h0, 32'hCAFEF00D, 1, 3, 2, 1'b1);

    // Stray ack while idle must not start a reply
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    check("idle_ack_tx", tx_valid, 1'b0);
    check("idle_ack_state", dbg.state, ST_IDLE);

    // Asynchronous reset in the middle of a stalled request
    send_byte(8'h09);
    check("pre_rst_stb", stb, 1'b1);
    stall = 1'b1;
    step();
    #2 rst = 1'b1;
    #1;
    check("async_rst_cyc", cyc, 1'b0);
    check("async_rst_stb", stb, 1'b0);
    check("async_rst_tx", tx_valid, 1'b0);
    stall = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("post_rst_dat", dat_o, 32'h0);
    check("post_rst_adr", adr, 0);
    check("post_rst_state", dbg.state, ST_IDLE);
    do_txn(8'h8A, 32'h0BADF00D, $urandom, 2, 2, 0, 1'b0);

    // No-ack behaviour
    send_byte(8'h02);
    check("tmo_stb", stb, 1'b1);
`ifdef UART_WB_TIMEOUT_EN
    for (int i = 1; i < TMO; i++) begin
      step();
      check("tmo_cyc_held", cyc, 1'b1);
    end
    step();
    check("tmo_cyc_drop", cyc, 1'b0);
    check("tmo_tx_valid", tx_valid, 1'b1);
    exp_q.push_back(NAK_BYTE);
    collect_reply(1, 0);
`else
    for (int i = 0; i < 20; i++) begin
      step();
      check("no_tmo_cyc", cyc, 1'b1);
    end
    ack   = 1'b1;
    dat_i = 32'hA5A50F0F;
    step();
    ack   = 1'b0;
    check("late_ack_cyc", cyc, 1'b0);
    check("late_ack_tx", tx_valid, 1'b1);
    for (int i = 3; i >= 0; i--) exp_q.push_back(8'hA5 ^ ((i < 2) ? 8'hAA : 8'h00));
    collect_reply(4, 0);
`endif

    // Randomized frames, reserved command bits included
    for (int t = 0; t < 24; t++) begin
      do_txn(8'($urandom), $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
